// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode timings, sync polarity
// constants and an elaboration-time width helper.
package vga_pkg;

    typedef struct packed {
        int h_display;
        int h_front;
        int h_sync;
        int h_back;
        int v_display;
        int v_front;
        int v_sync;
        int v_back;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_display: 32'd640, h_front: 32'd16, h_sync: 32'd96, h_back: 32'd48,
        v_display: 32'd480, v_front: 32'd10, v_sync: 32'd2,  v_back: 32'd33
    };

    // 40 MHz pixel clock
    localparam vga_timing_t SVGA_800x600_60 = '{
        h_display: 32'd800, h_front: 32'd40, h_sync: 32'd128, h_back: 32'd88,
        v_display: 32'd600, v_front: 32'd1,  v_sync: 32'd4,   v_back: 32'd23
    };

    localparam bit SYNC_NEG = 1'b0;
    localparam bit SYNC_POS = 1'b1;

    function automatic bit fits_in(input int value, input int width);
        return (value >= 32'sd0) && (longint'(value) < (64'sd1 <<< width));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 10,
    parameter int FRAME_W = 8
);
    logic               pix_en;
    logic [CNT_W-1:0]   hpos;
    logic [CNT_W-1:0]   vpos;
    logic               hsync;
    logic               vsync;
    logic               display_on;
    logic               vblank;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  pix_en,
        output hpos, vpos, hsync, vsync, display_on, vblank,
        output line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_en,
        input  hpos, vpos, hsync, vsync, display_on, vblank,
        input  line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with sync and active-area flags registered
// from the next position so they stay aligned with pos.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter bit POL     = SYNC_NEG,
    parameter int W       = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         sync,
    output logic         active,
    output logic         wrap
);
    localparam logic [W-1:0] MAX_POS    = W'(DISPLAY + FRONT + SYNC + BACK - 1);
    localparam logic [W-1:0] SYNC_FIRST = W'(DISPLAY + FRONT);
    localparam logic [W-1:0] SYNC_LAST  = W'(DISPLAY + FRONT + SYNC - 1);
    localparam logic [W-1:0] ACTIVE_END = W'(DISPLAY);

    logic [W-1:0] pos_r;
    logic [W-1:0] next_pos_s;
    logic         sync_r;
    logic         active_r;

    assign wrap = (pos_r == MAX_POS);

    // Next position: hold, wrap to zero, or increment
    always_comb begin
        next_pos_s = pos_r;
        if (!step) begin
            next_pos_s = pos_r;
        end else if (wrap) begin
            next_pos_s = {W{1'b0}};
        end else begin
            next_pos_s = pos_r + W'(1);
        end
    end

    // Position and its decoded flags, registered on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_r    <= MAX_POS;
            sync_r   <= ~POL;
            active_r <= 1'b0;
        end else begin
            pos_r    <= next_pos_s;
            sync_r   <= ((next_pos_s >= SYNC_FIRST) && (next_pos_s <= SYNC_LAST)) ? POL : ~POL;
            active_r <= (next_pos_s < ACTIVE_END);
        end
    end

    assign pos    = pos_r;
    assign sync   = sync_r;
    assign active = active_r;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: chained horizontal/vertical
// counters, line/frame strobes and a wrapping frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY  = VGA_640x480_60.h_display,
    parameter int H_FRONT    = VGA_640x480_60.h_front,
    parameter int H_SYNC     = VGA_640x480_60.h_sync,
    parameter int H_BACK     = VGA_640x480_60.h_back,
    parameter int V_DISPLAY  = VGA_640x480_60.v_display,
    parameter int V_FRONT    = VGA_640x480_60.v_front,
    parameter int V_SYNC     = VGA_640x480_60.v_sync,
    parameter int V_BACK     = VGA_640x480_60.v_back,
    parameter bit H_SYNC_POL = SYNC_NEG,
    parameter bit V_SYNC_POL = SYNC_NEG,
    parameter int CNT_W      = 10,
    parameter int FRAME_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  bus
);
    localparam int H_MAX = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_MAX = V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1;

    if (!fits_in(H_MAX, CNT_W) || !fits_in(V_MAX, CNT_W)) begin : g_width_check
        $error("vga_timing_gen: H_MAX/V_MAX do not fit in CNT_W bits");
    end

    logic               h_wrap_s;
    logic               v_wrap_s;
    logic               v_step_s;
    logic               h_active_r;
    logic               v_active_r;
    logic               line_start_r;
    logic               frame_start_r;
    logic [FRAME_W-1:0] frame_cnt_r;

    // The vertical axis only moves on the pixel tick that wraps the line
    assign v_step_s = bus.pix_en & h_wrap_s;

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .POL(H_SYNC_POL), .W(CNT_W)
    ) u_h_axis (
        .clk(clk), .reset(reset), .step(bus.pix_en),
        .pos(bus.hpos), .sync(bus.hsync), .active(h_active_r), .wrap(h_wrap_s)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .POL(V_SYNC_POL), .W(CNT_W)
    ) u_v_axis (
        .clk(clk), .reset(reset), .step(v_step_s),
        .pos(bus.vpos), .sync(bus.vsync), .active(v_active_r), .wrap(v_wrap_s)
    );

    // Line/frame strobes and the frame counter, aligned with the position wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_cnt_r   <= {FRAME_W{1'b0}};
        end else begin
            line_start_r  <= v_step_s;
            frame_start_r <= v_step_s & v_wrap_s;
            if (v_step_s && v_wrap_s) begin
                frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign bus.display_on  = h_active_r & v_active_r;
    assign bus.vblank      = ~v_active_r;
    assign bus.line_start  = line_start_r;
    assign bus.frame_start = frame_start_r;
    assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 640x480, a tiny positive-
// polarity raster with FRAME_W=2, and the SVGA 800x600 timing set.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct packed {
        logic [10:0] hpos;
        logic [10:0] vpos;
        logic        hs;
        logic        vs;
        logic        don;
        logic        vb;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    typedef struct {
        int    run;
        string nm;
        obs_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) b0 ();
    vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(2)) b1 ();
    vga_timing_gen_if #(.CNT_W(11), .FRAME_W(8)) b2 ();

    vga_timing_gen u0 (.clk(clk), .reset(rst0), .bus(b0));

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(SYNC_POS), .V_SYNC_POL(SYNC_POS), .CNT_W(4), .FRAME_W(2)
    ) u1 (.clk(clk), .reset(rst1), .bus(b1));

    vga_timing_gen #(
        .H_DISPLAY(SVGA_800x600_60.h_display), .H_FRONT(SVGA_800x600_60.h_front),
        .H_SYNC(SVGA_800x600_60.h_sync),       .H_BACK(SVGA_800x600_60.h_back),
        .V_DISPLAY(SVGA_800x600_60.v_display), .V_FRONT(SVGA_800x600_60.v_front),
        .V_SYNC(SVGA_800x600_60.v_sync),       .V_BACK(SVGA_800x600_60.v_back),
        .H_SYNC_POL(SYNC_POS), .V_SYNC_POL(SYNC_POS), .CNT_W(11), .FRAME_W(8)
    ) u2 (.clk(clk), .reset(rst1), .bus(b2));

    int vectors = 0;
    int misses  = 0;

    // reference raster state for u0 and u1
    int h0, v0, fc0;
    bit ls0, fs0;
    int h1, v1, fc1;
    bit ls1, fs1;
    obs_t q0[$];
    obs_t q1[$];
    vec_t tab[11];

    function automatic obs_t mk(input int h, input int v, input bit hs, input bit vs,
                                input bit don, input bit vb, input bit ls, input bit fs,
                                input int fc);
        obs_t o;
        o.hpos = 11'(h); o.vpos = 11'(v); o.hs = hs; o.vs = vs;
        o.don = don; o.vb = vb; o.ls = ls; o.fs = fs; o.fc = 8'(fc);
        return o;
    endfunction

    function automatic obs_t expect_obs(input int h, input int v, input int fc,
                                        input bit ls, input bit fs,
                                        input int hd, input int hf, input int hsw,
                                        input int vd, input int vf, input int vsw,
                                        input bit hp, input bit vp);
        bit hs_in;
        bit vs_in;
        hs_in = (h >= hd + hf) && (h <= hd + hf + hsw - 1);
        vs_in = (v >= vd + vf) && (v <= vd + vf + vsw - 1);
        return mk(h, v, hs_in ? hp : ~hp, vs_in ? vp : ~vp,
                  (h < hd) && (v < vd), v >= vd, ls, fs, fc);
    endfunction

    function automatic obs_t exp0();
        return expect_obs(h0, v0, fc0, ls0, fs0, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
    endfunction

    function automatic obs_t exp1();
        return expect_obs(h1, v1, fc1, ls1, fs1, 8, 2, 3, 4, 1, 2, 1'b1, 1'b1);
    endfunction

    function automatic obs_t dut0();
        return mk(int'(b0.hpos), int'(b0.vpos), b0.hsync, b0.vsync, b0.display_on,
                  b0.vblank, b0.line_start, b0.frame_start, int'(b0.frame_cnt));
    endfunction

    function automatic obs_t dut1();
        return mk(int'(b1.hpos), int'(b1.vpos), b1.hsync, b1.vsync, b1.display_on,
                  b1.vblank, b1.line_start, b1.frame_start, int'(b1.frame_cnt));
    endfunction

    function automatic string show(input obs_t o);
        return $sformatf("hpos=%0d vpos=%0d hs=%b vs=%b don=%b vb=%b ls=%b fs=%b fc=%0d",
                         o.hpos, o.vpos, o.hs, o.vs, o.don, o.vb, o.ls, o.fs, o.fc);
    endfunction

    task automatic cmp(input string nm, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got {%s} want {%s}", nm, show(act), show(exp));
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misses++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic adv(input bit pe, input int hmax, input int vmax, input int fmod,
                       inout int h, inout int v, inout int fc, inout bit ls, inout bit fs);
        if (pe) begin
            ls = (h == hmax);
            fs = ls && (v == vmax);
            if (h == hmax) begin
                h = 0;
                v = (v == vmax) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
            if (fs) fc = (fc + 1) % fmod;
        end else begin
            ls = 1'b0;
            fs = 1'b0;
        end
    endtask

    task automatic model_reset0();
        h0 = 799; v0 = 524; fc0 = 0; ls0 = 1'b0; fs0 = 1'b0;
    endtask

    // one clock: drive pix_en, queue the expected raster, compare after the edge
    task automatic cycle(input bit pe0, input bit pe1, input bit pe2);
        b0.pix_en = pe0;
        b1.pix_en = pe1;
        b2.pix_en = pe2;
        adv(pe0, 799, 524, 256, h0, v0, fc0, ls0, fs0);
        q0.push_back(exp0());
        adv(pe1, 14, 7, 4, h1, v1, fc1, ls1, fs1);
        q1.push_back(exp1());
        @(posedge clk);
        #1;
        cmp("sb_640", dut0(), q0.pop_front());
        cmp("sb_tiny", dut1(), q1.pop_front());
    endtask

    task automatic set_vec(input int i, input int run, input string nm, input obs_t o);
        tab[i].run = run;
        tab[i].nm  = nm;
        tab[i].exp = o;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs_lo, first_hs, last_hs, ls_cnt;
        int fs_n, last_fs, hs_hi, vs_hi;
        int fc_seen[$];
        int fc_want[5];

        //            run  name           hpos vpos hs vs don vb ls fs fc
        set_vec(0,   0,   "reset",       mk(799, 524, 1, 1, 0, 1, 0, 0, 0));
        set_vec(1,   1,   "first_pix",   mk(0,   0,   1, 1, 1, 0, 1, 1, 1));
        set_vec(2,   1,   "strobe_clr",  mk(1,   0,   1, 1, 1, 0, 0, 0, 1));
        set_vec(3,   638, "last_vis",    mk(639, 0,   1, 1, 1, 0, 0, 0, 1));
        set_vec(4,   1,   "first_blank", mk(640, 0,   1, 1, 0, 0, 0, 0, 1));
        set_vec(5,   15,  "pre_hsync",   mk(655, 0,   1, 1, 0, 0, 0, 0, 1));
        set_vec(6,   1,   "hsync_on",    mk(656, 0,   0, 1, 0, 0, 0, 0, 1));
        set_vec(7,   95,  "hsync_last",  mk(751, 0,   0, 1, 0, 0, 0, 0, 1));
        set_vec(8,   1,   "hsync_off",   mk(752, 0,   1, 1, 0, 0, 0, 0, 1));
        set_vec(9,   47,  "line_end",    mk(799, 0,   1, 1, 0, 0, 0, 0, 1));
        set_vec(10,  1,   "line_wrap",   mk(0,   1,   1, 1, 1, 0, 1, 0, 1));
        fc_want = '{1, 2, 3, 0, 1};

        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.pix_en = 1'b0;
        b1.pix_en = 1'b0;
        b2.pix_en = 1'b0;
        model_reset0();
        h1 = 14; v1 = 7; fc1 = 0; ls1 = 1'b0; fs1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        for (int i = 0; i < 11; i++) begin
            repeat (tab[i].run) cycle(1'b1, 1'b0, 1'b0);
            cmp(tab[i].nm, dut0(), tab[i].exp);
        end

        // one full line: hsync window and line_start period
        hs_lo = 0; first_hs = -1; last_hs = -1; ls_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (!b0.hsync) begin
                hs_lo++;
                if (first_hs < 0) first_hs = int'(b0.hpos);
                last_hs = int'(b0.hpos);
            end
            if (b0.line_start) ls_cnt++;
        end
        chk("hsync_width", hs_lo, 96);
        chk("hsync_first", first_hs, 656);
        chk("hsync_last_pos", last_hs, 751);
        chk("line_period", ls_cnt, 1);
        cmp("line2_start", dut0(), mk(0, 2, 1, 1, 1, 0, 1, 0, 1));

        // pix_en low: everything holds, strobe drops
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cmp("hold", dut0(), mk(0, 2, 1, 1, 1, 0, 0, 0, 1));

        // asynchronous reset in the middle of a line
        repeat (300) cycle(1'b1, 1'b0, 1'b0);
        cmp("mid_line", dut0(), mk(300, 2, 1, 1, 1, 0, 0, 0, 1));
        #2;
        b0.pix_en = 1'b1;
        rst0 = 1'b1;
        #1;
        cmp("async_rst", dut0(), mk(799, 524, 1, 1, 0, 1, 0, 0, 0));
        model_reset0();
        @(posedge clk);
        #1;
        cmp("rst_held", dut0(), mk(799, 524, 1, 1, 0, 1, 0, 0, 0));
        rst0 = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        cmp("restart", dut0(), mk(0, 0, 1, 1, 1, 0, 1, 1, 1));

        // tiny raster, pix_en every 2nd clock, 5 frames with FRAME_W=2
        fs_n = 0; last_fs = -1; hs_hi = 0; vs_hi = 0;
        for (int k = 0; k < 1200; k++) begin
            cycle(1'b0, (k % 2) == 0, 1'b0);
            if (b1.frame_start) begin
                fs_n++;
                fc_seen.push_back(int'(b1.frame_cnt));
                if (last_fs >= 0) chk("frame_period", k - last_fs, 240);
                last_fs = k;
            end
            if (b1.hsync) hs_hi++;
            if (b1.vsync) vs_hi++;
        end
        chk("frame_starts", fs_n, 5);
        chk("tiny_hsync_clks", hs_hi, 240);
        chk("tiny_vsync_clks", vs_hi, 300);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("frame_cnt_%0d", i), (i < fc_seen.size()) ? fc_seen[i] : -1, fc_want[i]);
        end

        // SVGA timing set, positive sync, one full line
        hs_hi = 0; vs_hi = 0; first_hs = -1; last_hs = -1;
        for (int k = 0; k < 1056; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            if (b2.hsync) begin
                hs_hi++;
                if (first_hs < 0) first_hs = int'(b2.hpos);
                last_hs = int'(b2.hpos);
            end
            if (b2.vsync) vs_hi++;
        end
        chk("svga_hsync_width", hs_hi, 128);
        chk("svga_hsync_first", first_hs, 840);
        chk("svga_hsync_last", last_hs, 967);
        chk("svga_vsync_idle", vs_hi, 0);
        chk("svga_hmax", int'(b2.hpos), 1055);
        cycle(1'b0, 1'b0, 1'b1);
        chk("svga_wrap_h", int'(b2.hpos), 0);
        chk("svga_wrap_v", int'(b2.vpos), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
